// File: rtl/hough_pkg.sv
// -----------------------------------------------------------------------------
// hough_pkg
// Definitions shared by the Hough edge-point extractor and the voting stage:
// default image geometry, coordinate widths, the point record and the raster
// tracking state.
// -----------------------------------------------------------------------------
package hough_pkg;

    localparam int HOUGH_IMG_W = 320;
    localparam int HOUGH_IMG_H = 240;
    localparam int HOUGH_X_W   = 9;
    localparam int HOUGH_Y_W   = 8;

    // Point record exchanged with the voting stage; x sits in the upper bits.
    typedef struct packed {
        logic [HOUGH_X_W-1:0] x;
        logic [HOUGH_Y_W-1:0] y;
    } hough_point_t;

    // Raster tracking state: IDLE until a start-of-frame beat locks the raster.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } raster_state_t;

endpackage

// File: rtl/hough_point_fifo.sv
// -----------------------------------------------------------------------------
// hough_point_fifo
// Synchronous first-word-fall-through FIFO for edge-point coordinates.
// The head entry is always presented on o_data while o_valid is high.
// A push and a pop in the same cycle are legal at any occupancy, including full.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous, active-high reset (empties the FIFO)
//   i_push          write i_data (ignored when full without a simultaneous pop)
//   i_data          entry to write
//   i_pop           consume the head entry (ignored when empty)
//   o_valid         FIFO holds at least one entry
//   o_data          head entry
//   o_not_full_nxt  occupancy after this cycle's push/pop will be below DEPTH
// -----------------------------------------------------------------------------
module hough_point_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_not_full_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // NOTE: storage is not reset; the count alone defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid        = (r_count != '0);
    assign o_data         = r_mem[r_rd_ptr];
    assign o_not_full_nxt = (w_count_nxt != FULL_CNT);

endmodule

// File: rtl/hough_edge_point_extractor.sv
// -----------------------------------------------------------------------------
// hough_edge_point_extractor
// Feeder of the Hough voting stage. Tracks (x,y) over a raster-ordered 1-bit
// edge stream, queues the coordinates of every edge pixel (and of the
// start-of-frame pixel) and emits them over valid/ready. Reports frame
// completion with a per-frame point count, and raster-sync errors.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   pix_valid/ready pixel beat handshake (pix_ready registered, low in reset)
//   pix_edge        beat is an edge pixel
//   pix_sof         beat is pixel (0,0)
//   pt_valid/ready  point handshake towards the voting stage
//   pt_x, pt_y      head point coordinates (0 while pt_valid is low)
//   frame_done      1-cycle pulse after the last pixel of a frame is accepted
//   frame_pts       points pushed in the completed frame, valid with frame_done
//   sync_err        1-cycle pulse when a start-of-frame interrupts a frame
// -----------------------------------------------------------------------------
module hough_edge_point_extractor
    import hough_pkg::*;
#(
    parameter int IMG_W      = HOUGH_IMG_W,
    parameter int IMG_H      = HOUGH_IMG_H,
    parameter int X_W        = HOUGH_X_W,
    parameter int Y_W        = HOUGH_Y_W,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_edge,
    input  logic             pix_sof,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [X_W-1:0]   pt_x,
    output logic [Y_W-1:0]   pt_y,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_pts,
    output logic             sync_err
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    raster_state_t    r_state;
    raster_state_t    w_state_nxt;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_frame_pts;
    logic             r_pix_ready;
    logic             r_frame_done;
    logic             r_sync_err;

    logic             w_accept;
    logic             w_sof_acc;
    logic             w_scan_beat;
    logic             w_last;
    logic             w_push;
    logic             w_done;
    logic             w_err;
    logic [X_W+Y_W-1:0] w_pt_in;
    logic [X_W+Y_W-1:0] w_head;
    logic [X_W-1:0]   w_head_x;
    logic [Y_W-1:0]   w_head_y;
    logic             w_fifo_valid;
    logic             w_not_full_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_accept = pix_valid && r_pix_ready;
    assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: if (pix_sof) w_state_nxt = ST_SCAN;
                ST_SCAN: begin
                    if (pix_sof) begin
                        w_state_nxt = ST_SCAN;
                    end else if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_sof_acc   = w_accept && pix_sof;
        w_scan_beat = w_accept && !pix_sof && (r_state == ST_SCAN);
        // The sof beat is pixel (0,0) and is always queued, edge or not.
        w_push      = w_sof_acc || (w_scan_beat && pix_edge);
        w_done      = w_scan_beat && w_last;
        w_err       = w_sof_acc && (r_state == ST_SCAN);
        w_pt_in     = w_sof_acc ? '0 : {r_x, r_y};
    end

    // Raster position of the next beat; a sof beat is (0,0), so the next is (1,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_sof_acc) begin
            r_x <= X_W'(1);
            r_y <= '0;
        end else if (w_scan_beat) begin
            if (w_last) begin
                r_x <= '0;
                r_y <= '0;
            end else if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    // Per-frame push counter; the sof push seeds it with 1, an aborted frame restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_frame_pts  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_pix_ready  <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            r_sync_err   <= w_err;
            // Registered from next-cycle occupancy, so a beat is never offered a full FIFO.
            r_pix_ready  <= w_not_full_nxt;
            if (w_sof_acc) begin
                r_cnt <= CNT_W'(1);
            end else if (w_done) begin
                r_cnt <= '0;
            end else if (w_push) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (w_done) begin
                r_frame_pts <= w_push ? sat_inc(r_cnt) : r_cnt;
            end
        end
    end

    hough_point_fifo #(
        .WIDTH (X_W + Y_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_data         (w_pt_in),
        .i_pop          (pt_ready),
        .o_valid        (w_fifo_valid),
        .o_data         (w_head),
        .o_not_full_nxt (w_not_full_nxt)
    );

    assign {w_head_x, w_head_y} = w_head;

    assign pix_ready  = r_pix_ready;
    assign pt_valid   = w_fifo_valid;
    // Unwritten storage never reaches the outputs: coordinates read 0 when no point is queued.
    assign pt_x       = w_fifo_valid ? w_head_x : '0;
    assign pt_y       = w_fifo_valid ? w_head_y : '0;
    assign frame_done = r_frame_done;
    assign frame_pts  = r_frame_pts;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_hough_edge_point_extractor.sv
// -----------------------------------------------------------------------------
// Directed bench for hough_edge_point_extractor on a 4x3 image, 4-entry FIFO.
// -----------------------------------------------------------------------------
module tb_hough_edge_point_extractor;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int DEPTH = 4;
    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 17;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_edge = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pt_ready = 1'b0;
    logic          pix_ready;
    logic          pt_valid;
    logic [XW-1:0] pt_x;
    logic [YW-1:0] pt_y;
    logic          frame_done;
    logic [CW-1:0] frame_pts;
    logic          sync_err;

    always #5 clk = ~clk;

    hough_edge_point_extractor #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .X_W        (XW),
        .Y_W        (YW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_edge   (pix_edge),
        .pix_sof    (pix_sof),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .frame_done (frame_done),
        .frame_pts  (frame_pts),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic e;      // pix_edge
        logic s;      // pix_sof
        logic pv;     // expected pt_valid after the beat
        int   x;
        int   y;
        logic fd;     // expected frame_done pulse
        int   fpts;
        logic se;     // expected sync_err pulse
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_fd = 0;
    int   n_se = 0;
    int   last_fpts = 0;
    bit   sending = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic e, input logic s, input logic pv, input int x,
                                input int y, input logic fd, input int fpts, input logic se);
        vec_t v;
        v.e = e; v.s = s; v.pv = pv; v.x = x; v.y = y; v.fd = fd; v.fpts = fpts; v.se = se;
        vecs.push_back(v);
    endfunction

    // Pulse monitor: each frame_done / sync_err pulse is seen exactly once at negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                n_fd++;
                last_fpts = int'(frame_pts);
            end
            if (sync_err) n_se++;
        end
    end

    task automatic idle_inputs();
        pix_valid = 1'b0;
        pix_edge  = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Entered and left at posedge+1; returns once the beat has been accepted.
    task automatic send_beat(input logic e, input logic s);
        int  t;
        bit  acc;
        pix_valid = 1'b1;
        pix_edge  = e;
        pix_sof   = s;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            acc = pix_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("beat_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!pix_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ready_after_reset", pix_ready, 1);
    endtask

    // One full frame (bit i of mask = edge at raster index i), points collected
    // after stall cycles of back-pressure.
    task automatic run_frame(input logic [NPIX-1:0] mask, input int stall, input bit check_drop);
        int exp_idx[$];
        int fd0;
        int se0;
        for (int i = 0; i < NPIX; i++) begin
            if (i == 0 || mask[i]) exp_idx.push_back(i);
        end
        fd0 = n_fd;
        se0 = n_se;
        pt_ready = 1'b0;
        fork
            begin
                sending = 1'b1;
                for (int i = 0; i < NPIX; i++) send_beat(mask[i], i == 0);
                sending = 1'b0;
                idle_inputs();
            end
            begin
                int t;
                int got;
                int lows;
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
                if (check_drop) begin
                    check("ready_drop_full", pix_ready, 0);
                    check("held_pt_valid", pt_valid, 1);
                    check("held_pt_x", pt_x, 0);
                    check("held_pt_y", pt_y, 0);
                end
                pt_ready = 1'b1;
                t = 0;
                got = 0;
                lows = 0;
                while (t < 300 && (got < exp_idx.size() || n_fd == fd0 || sending)) begin
                    if (pt_valid) begin
                        if (got < exp_idx.size()) begin
                            check("pt_x_order", pt_x, exp_idx[got] % IMG_W);
                            check("pt_y_order", pt_y, exp_idx[got] / IMG_W);
                        end else begin
                            check("extra_point", 1, 0);
                        end
                        got++;
                    end
                    if (t > 0 && sending && !pix_ready) lows++;
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("pt_count", got, exp_idx.size());
                check("ready_steady", lows, 0);
                check("frame_done_cnt", n_fd - fd0, 1);
                check("frame_pts", last_fpts, exp_idx.size());
                check("sync_err_cnt", n_se - se0, 0);
                check("drained", pt_valid, 0);
            end
        join
    endtask

    initial begin
        int fd0;
        int se0;

        // Stray beats before lock (edge set, no sof): accepted, nothing queued.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // Frame with a single edge at (2,1).
        for (int i = 0; i < NPIX; i++) begin
            add(i == 6, i == 0, (i == 0) || (i == 6), i % IMG_W, i / IMG_W, i == NPIX - 1, 2, 0);
        end
        // Frame aborted by a sof at beat 5, then a complete frame.
        for (int i = 0; i < 5; i++) begin
            add(i == 1, i == 0, (i == 0) || (i == 1), i % IMG_W, i / IMG_W, 0, 0, 0);
        end
        add(0, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 1; i < NPIX; i++) begin
            add((i == 7) || (i == 11), 0, (i == 7) || (i == 11), i % IMG_W, i / IMG_W,
                i == NPIX - 1, 3, 0);
        end

        // Reset state.
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_pt_valid", pt_valid, 0);
        check("rst_pt_x", pt_x, 0);
        check("rst_pt_y", pt_y, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_pts", frame_pts, 0);
        check("rst_sync_err", sync_err, 0);
        rst = 1'b0;
        wait_ready();

        // Table: one beat per cycle, pt_ready high, outputs sampled 1 time unit after the edge.
        pt_ready = 1'b1;
        foreach (vecs[k]) begin
            pix_valid = 1'b1;
            pix_edge  = vecs[k].e;
            pix_sof   = vecs[k].s;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pt_valid", k), pt_valid, vecs[k].pv);
            if (vecs[k].pv) begin
                check($sformatf("v%0d_pt_x", k), pt_x, vecs[k].x);
                check($sformatf("v%0d_pt_y", k), pt_y, vecs[k].y);
            end
            check($sformatf("v%0d_frame_done", k), frame_done, vecs[k].fd);
            if (vecs[k].fd) check($sformatf("v%0d_frame_pts", k), frame_pts, vecs[k].fpts);
            check($sformatf("v%0d_sync_err", k), sync_err, vecs[k].se);
            check($sformatf("v%0d_pix_ready", k), pix_ready, 1);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        check("table_drain", pt_valid, 0);

        // All pixels edge under back-pressure: fill, drop pix_ready, release, all 12 in order.
        run_frame({NPIX{1'b1}}, 8, 1'b1);

        // Full FIFO released while beats keep arriving: steady push+pop, order kept.
        run_frame(12'b1101_1101_1011, 8, 1'b1);

        // Reset mid-frame with three queued points.
        pt_ready = 1'b0;
        send_beat(1'b0, 1'b1);
        send_beat(1'b1, 1'b0);
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        idle_inputs();
        check("queued_pt_valid", pt_valid, 1);
        check("queued_pt_x", pt_x, 0);
        fd0 = n_fd;
        se0 = n_se;
        #2 rst = 1'b1;
        #1;
        check("midrst_pt_valid", pt_valid, 0);
        check("midrst_pix_ready", pix_ready, 0);
        check("midrst_pt_x", pt_x, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready();
        check("midrst_no_frame_done", n_fd - fd0, 0);
        check("midrst_no_sync_err", n_se - se0, 0);
        check("midrst_empty", pt_valid, 0);
        run_frame(12'b0000_0010_0000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
